// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: shared state encoding, mode codes and LFSR step for the AES trace sequencer
package aes_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_GAP,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [1:0] MODE_FIXED  = 2'b00;
    localparam logic [1:0] MODE_RANDOM = 2'b01;
    localparam logic [1:0] MODE_ALT    = 2'b10;

    localparam int LFSR_W = 128;

    // Taps for x^128 + x^7 + x^2 + x + 1 (the x^128 term is the shifted-out bit)
    localparam logic [LFSR_W-1:0] LFSR_POLY = 128'h87;

    // One Galois step: shift left, fold the outgoing MSB back through the taps
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], 1'b0} ^ (q[LFSR_W-1] ? LFSR_POLY : '0);
    endfunction

endpackage

// File: rtl/aes_lfsr128.sv
// aes_lfsr128: 128-bit Galois LFSR plaintext source, advances only when step is high
module aes_lfsr128
    import aes_seq_pkg::*;
#(
    parameter int                WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    output logic [WIDTH-1:0] q
);

    // Hold the seed after reset, advance one polynomial step per request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= SEED;
        else if (step) q <= lfsr_next(q);
    end

endmodule

// File: rtl/aes_trace_sequencer.sv
// aes_trace_sequencer: drives AES_top with fixed/random plaintexts and captures ciphertexts per trace
module aes_trace_sequencer
    import aes_seq_pkg::*;
#(
    parameter int                 DATA_W      = 128,
    parameter int                 NUM_TRACES  = 1000,
    parameter int                 CNT_W       = 16,
    parameter int                 GAP_CYCLES  = 15,
    parameter int                 TRIG_CYCLES = 4,
    parameter int                 TIMEOUT_CYC = 255,
    parameter logic [LFSR_W-1:0]  LFSR_SEED   = 1
) (
    input  logic              AES_clk,
    input  logic              AES_rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] fixed_pt,
    input  logic [DATA_W-1:0] key_cfg,
    output logic              aes_en,
    output logic [DATA_W-1:0] aes_data_in,
    output logic [DATA_W-1:0] aes_key_in,
    input  logic              aes_valid,
    input  logic [DATA_W-1:0] aes_data_out,
    output logic [DATA_W-1:0] ct_out,
    output logic              ct_valid,
    output logic              trigger,
    output logic [CNT_W-1:0]  trace_idx,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] N_TRACES  = CNT_W'(NUM_TRACES);

    state_t             state;
    logic [CNT_W-1:0]   run_cnt;
    logic [CNT_W-1:0]   gap_cnt;
    logic [LFSR_W-1:0]  lfsr_q;
    logic [CNT_W-1:0]   idx_nxt;
    logic               use_fixed;
    logic               last_trace;

    // Random plaintexts take the post-step LFSR value, so trace n sees step n+1 from the seed
    aes_lfsr128 #(.WIDTH(LFSR_W), .SEED(LFSR_SEED)) u_lfsr (
        .clk   (AES_clk),
        .rst_n (AES_rst_n),
        .step  (state == S_LOAD && !abort),
        .q     (lfsr_q)
    );

    assign idx_nxt    = trace_idx + CNT_W'(1);
    assign use_fixed  = (mode == MODE_RANDOM) ? 1'b0 : (mode == MODE_ALT) ? ~trace_idx[0] : 1'b1;
    assign last_trace = (NUM_TRACES != 0) && (idx_nxt == N_TRACES);

    // Campaign FSM: load plaintext, hold en until valid or timeout, idle gap, repeat
    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            state       <= S_IDLE;
            aes_en      <= 1'b0;
            aes_data_in <= '0;
            aes_key_in  <= '0;
            ct_out      <= '0;
            ct_valid    <= 1'b0;
            trigger     <= 1'b0;
            trace_idx   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            run_cnt     <= '0;
            gap_cnt     <= '0;
        end else begin
            ct_valid <= 1'b0;
            if (abort) begin
                state   <= S_IDLE;
                aes_en  <= 1'b0;
                trigger <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_ERR: begin
                        if (start) begin
                            state      <= S_LOAD;
                            trace_idx  <= '0;
                            done       <= 1'b0;
                            err        <= 1'b0;
                            busy       <= 1'b1;
                            aes_key_in <= key_cfg;
                        end
                    end
                    S_LOAD: begin
                        aes_data_in <= use_fixed ? fixed_pt : DATA_W'(lfsr_next(lfsr_q));
                        aes_en      <= 1'b1;
                        trigger     <= 1'b1;
                        run_cnt     <= '0;
                        state       <= S_RUN;
                    end
                    S_RUN: begin
                        run_cnt <= run_cnt + CNT_W'(1);
                        if (run_cnt == TRIG_LAST) trigger <= 1'b0;
                        if (aes_valid) begin
                            ct_out   <= aes_data_out;
                            ct_valid <= 1'b1;
                            aes_en   <= 1'b0;
                            trigger  <= 1'b0;
                            gap_cnt  <= '0;
                            state    <= S_GAP;
                        end else if (run_cnt == TO_LAST) begin
                            aes_en  <= 1'b0;
                            trigger <= 1'b0;
                            err     <= 1'b1;
                            busy    <= 1'b0;
                            state   <= S_ERR;
                        end
                    end
                    S_GAP: begin
                        gap_cnt <= gap_cnt + CNT_W'(1);
                        if (gap_cnt == GAP_LAST) begin
                            if (last_trace) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= S_DONE;
                            end else begin
                                trace_idx <= idx_nxt;
                                state     <= S_LOAD;
                            end
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// tb_aes_trace_sequencer: directed table and sequence checks of the AES trace sequencer against an AES stub
module tb_aes_trace_sequencer;

    localparam int GAP = 3;
    localparam int TRIG = 4;
    localparam int TMO = 255;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] PA  = 128'hcafef00d_12345678_9abcdef0_00000001;
    localparam logic [127:0] PB  = 128'h55555555_aaaaaaaa_33333333_cccccccc;
    localparam logic [127:0] PC  = 128'h01234567_89abcdef_fedcba98_76543210;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [127:0] fixed_pt = '0;
    logic [127:0] key_cfg = '0;

    logic         en[2];
    logic         valid[2];
    logic         ctv[2];
    logic         trig[2];
    logic         busy[2];
    logic         done[2];
    logic         err[2];
    logic [127:0] din[2];
    logic [127:0] kin[2];
    logic [127:0] dout[2];
    logic [127:0] ct[2];
    logic [15:0]  idx[2];

    int           lat = 2;
    int           en_cnt[2] = '{0, 0};
    int           checks = 0;
    int           errors = 0;
    int           pulses = 0;
    logic [127:0] pts[8];
    logic [127:0] cts[8];

    typedef struct {
        logic [1:0]   mode;
        logic [127:0] pt;
        logic [127:0] exp[4];
    } vec_t;
    vec_t v[4];

    always #5 clk = ~clk;

    aes_trace_sequencer #(.NUM_TRACES(4), .GAP_CYCLES(GAP), .TRIG_CYCLES(TRIG), .TIMEOUT_CYC(TMO)) u_dut (
        .AES_clk(clk), .AES_rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .fixed_pt(fixed_pt), .key_cfg(key_cfg), .aes_en(en[0]), .aes_data_in(din[0]),
        .aes_key_in(kin[0]), .aes_valid(valid[0]), .aes_data_out(dout[0]), .ct_out(ct[0]),
        .ct_valid(ctv[0]), .trigger(trig[0]), .trace_idx(idx[0]), .busy(busy[0]),
        .done(done[0]), .err(err[0])
    );

    aes_trace_sequencer #(.NUM_TRACES(1), .GAP_CYCLES(GAP), .TRIG_CYCLES(TRIG), .TIMEOUT_CYC(TMO)) u_one (
        .AES_clk(clk), .AES_rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .fixed_pt(fixed_pt), .key_cfg(key_cfg), .aes_en(en[1]), .aes_data_in(din[1]),
        .aes_key_in(kin[1]), .aes_valid(valid[1]), .aes_data_out(dout[1]), .ct_out(ct[1]),
        .ct_valid(ctv[1]), .trigger(trig[1]), .trace_idx(idx[1]), .busy(busy[1]),
        .done(done[1]), .err(err[1])
    );

    // AES stub: answers lat cycles into RUN; real ciphertext only for the FIPS-197 vector
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            valid[i] = en[i] && (en_cnt[i] == lat);
            dout[i]  = (din[i] == FIPS_PT && kin[i] == FIPS_KEY) ? FIPS_CT : din[i] ^ kin[i];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) en_cnt[i] <= en[i] ? en_cnt[i] + 1 : 0;
    end

    always @(negedge clk) begin
        if (ctv[0]) begin
            if (pulses < 8) begin
                pts[pulses] = din[0];
                cts[pulses] = ct[0];
            end
            pulses++;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        lat = 2;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        pulses = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_abort(input logic with_start);
        @(posedge clk);
        #1 abort = 1'b1;
        start = with_start;
        @(posedge clk);
        #1 abort = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_end(input int i);
        for (int k = 0; k < 3000 && !(done[i] || err[i]); k++) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        v[0].mode = 2'b00; v[0].pt = PA; v[0].exp = '{PA, PA, PA, PA};
        v[1].mode = 2'b01; v[1].pt = PA; v[1].exp = '{128'h2, 128'h4, 128'h8, 128'h10};
        v[2].mode = 2'b10; v[2].pt = PB; v[2].exp = '{PB, 128'h4, PB, 128'h10};
        v[3].mode = 2'b11; v[3].pt = PC; v[3].exp = '{PC, PC, PC, PC};

        // reset state
        do_reset();
        @(negedge clk);
        chk("reset en", en[0], 1'b0);
        chk("reset busy", busy[0], 1'b0);
        chk("reset done", done[0], 1'b0);
        chk("reset err", err[0], 1'b0);
        chk("reset key", kin[0], '0);
        chk("reset idx", idx[0], '0);

        // FIPS-197 single trace on the NUM_TRACES=1 instance
        do_reset();
        mode = 2'b00; key_cfg = FIPS_KEY; fixed_pt = FIPS_PT;
        pulse_start();
        wait_end(1);
        chk("fips done", done[1], 1'b1);
        chk("fips err", err[1], 1'b0);
        chk("fips ct", ct[1], FIPS_CT);
        chk("fips idx", idx[1], '0);

        // four-trace campaigns per mode from a fresh LFSR
        for (int i = 0; i < 4; i++) begin
            do_reset();
            mode = v[i].mode; fixed_pt = v[i].pt; key_cfg = KEY;
            pulse_start();
            wait_end(0);
            chk($sformatf("v%0d done", i), done[0], 1'b1);
            chk($sformatf("v%0d err", i), err[0], 1'b0);
            chk($sformatf("v%0d busy", i), busy[0], 1'b0);
            chk($sformatf("v%0d idx", i), idx[0], 16'd3);
            chk($sformatf("v%0d pulses", i), pulses, 4);
            for (int t = 0; t < 4; t++) begin
                chk($sformatf("v%0d pt%0d", i, t), pts[t], v[i].exp[t]);
                chk($sformatf("v%0d ct%0d", i, t), cts[t], v[i].exp[t] ^ KEY);
            end
        end

        // start-to-en latency, trigger width, gap length, start while busy
        do_reset();
        lat = 6; mode = 2'b00; fixed_pt = PA; key_cfg = KEY;
        pulse_start();
        @(negedge clk);
        chk("en at t0+1", en[0], 1'b0);
        @(negedge clk);
        chk("en at t0+2", en[0], 1'b1);
        n = trig[0] ? 1 : 0;
        for (int k = 0; k < 50 && !ctv[0]; k++) begin
            @(negedge clk);
            if (trig[0]) n++;
        end
        chk("trigger width", n, TRIG);
        n = 0;
        for (int k = 0; k < 50 && !en[0]; k++) begin
            n++;
            @(negedge clk);
        end
        chk("gap plus load low", n, GAP + 1);
        pulse_start();
        @(negedge clk);
        chk("start busy idx", idx[0], 16'd1);
        chk("start busy en", en[0], 1'b1);

        // timeout then restart clears err
        do_reset();
        lat = 1000; mode = 2'b00; fixed_pt = PA; key_cfg = KEY;
        pulse_start();
        n = 0;
        for (int k = 0; k < 400 && !err[0]; k++) begin
            @(negedge clk);
            if (en[0]) n++;
        end
        chk("timeout run cycles", n, TMO);
        chk("timeout err", err[0], 1'b1);
        chk("timeout en", en[0], 1'b0);
        chk("timeout busy", busy[0], 1'b0);
        lat = 2;
        pulse_start();
        @(negedge clk);
        chk("restart err clear", err[0], 1'b0);
        chk("restart busy", busy[0], 1'b1);

        // abort mid-RUN of trace 2, LFSR held across the abort
        do_reset();
        lat = 6; mode = 2'b01; key_cfg = KEY;
        pulse_start();
        for (int k = 0; k < 200 && !(idx[0] == 16'd2 && en[0]); k++) @(negedge clk);
        pulse_abort(1'b0);
        @(negedge clk);
        chk("abort en", en[0], 1'b0);
        chk("abort busy", busy[0], 1'b0);
        chk("abort trig", trig[0], 1'b0);
        chk("abort idx", idx[0], 16'd2);
        repeat (10) @(negedge clk);
        chk("abort no ct_valid", pulses, 2);
        pulse_abort(1'b1);
        @(negedge clk);
        chk("abort beats start", busy[0], 1'b0);
        pulses = 0;
        pulse_start();
        for (int k = 0; k < 50 && pulses == 0; k++) @(negedge clk);
        chk("lfsr held pt", pts[0], 128'h10);
        pulse_abort(1'b0);

        // valid exactly in the timeout cycle, then async reset mid-RUN
        do_reset();
        lat = TMO - 1; mode = 2'b00; fixed_pt = PA; key_cfg = KEY;
        pulse_start();
        for (int k = 0; k < 400 && !ctv[0] && !err[0]; k++) @(negedge clk);
        chk("edge valid captured", ctv[0], 1'b1);
        chk("edge valid no err", err[0], 1'b0);
        chk("edge valid ct", ct[0], PA ^ KEY);
        lat = 1000;
        for (int k = 0; k < 50 && !en[0]; k++) @(negedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("async rst en", en[0], 1'b0);
        chk("async rst trig", trig[0], 1'b0);
        chk("async rst busy", busy[0], 1'b0);
        chk("async rst idx", idx[0], '0);
        chk("async rst ct", ct[0], '0);
        chk("async rst din", din[0], '0);
        chk("async rst key", kin[0], '0);
        #10 rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
